// File: rtl/long_arith_pkg.sv
// Shared types and sizing helpers for the long_adder datapath and its operand feeder.
package long_arith_pkg;

    typedef enum logic {LOAD_A, LOAD_B} load_state_t;

    // Width of one long_adder carry segment; operand sizes are built from these.
    localparam int ADDER_SIZE = 18;

    function automatic int words_for(input int size, input int word);
        return (size + word - 1) / word;
    endfunction

    // long_adder pipeline depth for a given operand width; 0 marks an unsupported width.
    function automatic int latency_for(input int size);
        if (size < 72)       return 2;
        else if (size < 252) return 3;
        else if (size < 900) return 4;
        else                 return 0;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that delays a single valid bit by DEPTH clocks.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= (pipe << 1) | DEPTH'(din);
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/long_operand_loader.sv
// Deserialises a 32-bit word stream into double-buffered A/B operand pairs for long_adder.
module long_operand_loader
    import long_arith_pkg::*;
#(
    parameter int SIZE    = 576,
    parameter int WORD    = 32,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [WORD-1:0] s_data,
    output logic [SIZE-1:0] din_a,
    output logic [SIZE-1:0] din_b,
    output logic            issue,
    output logic            res_valid,
    output logic [15:0]     pair_cnt
);

    localparam int NWORDS = words_for(SIZE, WORD);
    localparam int SHW    = NWORDS * WORD;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [SHW-1:0]   WMASK    = SHW'({WORD{1'b1}});

    if (LATENCY != latency_for(SIZE)) begin : g_latency_check
        $error("long_operand_loader: LATENCY does not match long_adder depth for SIZE");
    end
    if (SIZE % ADDER_SIZE != 0) begin : g_size_check
        $warning("long_operand_loader: SIZE is not a whole number of adder segments");
    end

    // Writes one stream word into word slot idx; bits beyond SIZE fall off the top.
    function automatic logic [SIZE-1:0] place_word(input logic [SIZE-1:0] cur,
                                                   input logic [WORD-1:0] w,
                                                   input int              idx);
        return SIZE'((SHW'(cur) & ~(WMASK << (idx * WORD))) | (SHW'(w) << (idx * WORD)));
    endfunction

    load_state_t      state, state_next;
    logic [IDX_W-1:0] word_idx, idx_next;
    logic             transfer;
    logic             complete;
    logic [SIZE-1:0]  shadow_a, shadow_b;
    logic [SIZE-1:0]  merged_b;

    assign transfer = s_valid & s_ready;
    assign merged_b = place_word(shadow_b, s_data, NWORDS - 1);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = word_idx;
        complete   = 1'b0;
        if (clear) begin
            state_next = LOAD_A;
            idx_next   = '0;
        end else if (transfer) begin
            if (word_idx == LAST_IDX) begin
                idx_next   = '0;
                state_next = (state == LOAD_A) ? LOAD_B : LOAD_A;
                complete   = (state == LOAD_B);
            end else begin
                idx_next = word_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            word_idx <= '0;
        end else begin
            state    <= state_next;
            word_idx <= idx_next;
        end
    end

    // NOTE: the shadow buffers are plain registers and are reset so a partial pair never leaks stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready  <= 1'b0;
            shadow_a <= '0;
            shadow_b <= '0;
            din_a    <= '0;
            din_b    <= '0;
            issue    <= 1'b0;
            pair_cnt <= '0;
        end else begin
            s_ready <= 1'b1;
            issue   <= complete;
            if (transfer && !clear) begin
                if (state == LOAD_A) shadow_a <= place_word(shadow_a, s_data, int'(word_idx));
                else                 shadow_b <= place_word(shadow_b, s_data, int'(word_idx));
            end
            // The last B word goes straight into din_b; shadow_b only holds the lower words.
            if (complete) begin
                din_a    <= shadow_a;
                din_b    <= merged_b;
                pair_cnt <= pair_cnt + 16'd1;
            end
        end
    end

    valid_delay_line #(.DEPTH(LATENCY)) u_res_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (issue),
        .dout  (res_valid)
    );

endmodule

// File: tb/tb_long_operand_loader.sv
// Directed and randomized checks of long_operand_loader against a word-queue reference model.
module tb_long_operand_loader;

    localparam int SIZE    = 72;
    localparam int WORD    = 32;
    localparam int LATENCY = 3;
    localparam int NW      = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             s_valid = 1'b0;
    logic [WORD-1:0]  s_data = '0;
    logic             s_ready;
    logic [SIZE-1:0]  din_a, din_b;
    logic             issue, res_valid;
    logic [15:0]      pair_cnt;

    always #5 clk = ~clk;

    long_operand_loader #(.SIZE(SIZE), .WORD(WORD), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .din_a     (din_a),
        .din_b     (din_b),
        .issue     (issue),
        .res_valid (res_valid),
        .pair_cnt  (pair_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int rv_seen     = 0;
    int issue_seen  = 0;

    // Reference model: accepted words of the pair in progress, last issued pair, and
    // the cycle numbers at which issued pairs are owed a res_valid.
    logic [31:0] words[$];
    logic [71:0] m_a, m_b;
    bit          m_issue, m_ready;
    int          m_cnt;
    int          issue_at[$];
    logic [71:0] sum_q[$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_reset();
        words.delete();
        issue_at.delete();
        sum_q.delete();
        m_a = '0; m_b = '0; m_issue = 0; m_ready = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag, input bit exp_rv);
        check({tag, ".s_ready"},   72'(s_ready),   72'(m_ready));
        check({tag, ".issue"},     72'(issue),     72'(m_issue));
        check({tag, ".din_a"},     din_a,          m_a);
        check({tag, ".din_b"},     din_b,          m_b);
        check({tag, ".pair_cnt"},  72'(pair_cnt),  72'(m_cnt));
        check({tag, ".res_valid"}, 72'(res_valid), 72'(exp_rv));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit v, input logic [31:0] d, input bit clr);
        logic [95:0] wa, wb;
        logic [71:0] dut_sum, exp_sum;
        bit          exp_rv;
        s_valid = v; s_data = d; clear = clr;
        @(posedge clk);
        #1;
        cycle++;
        m_issue = 0;
        if (clr) begin
            words.delete();
        end else if (v && m_ready) begin
            words.push_back(d);
            if (words.size() == 2 * NW) begin
                wa = {words[2], words[1], words[0]};
                wb = {words[5], words[4], words[3]};
                m_a = wa[71:0];
                m_b = wb[71:0];
                m_issue = 1;
                m_cnt = (m_cnt + 1) % 65536;
                issue_at.push_back(cycle);
                exp_sum = m_a + m_b;
                sum_q.push_back(exp_sum);
                words.delete();
            end
        end
        m_ready = 1;
        exp_rv = (issue_at.size() > 0) && (issue_at[0] + LATENCY == cycle);
        check_outputs("step", exp_rv);
        if (exp_rv) begin
            void'(issue_at.pop_front());
            exp_sum = sum_q.pop_front();
            dut_sum = din_a + din_b;
            check("adder_dout", dut_sum, exp_sum);
        end
        if (res_valid) rv_seen++;
        if (issue) issue_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic send_pair(input logic [31:0] w0, w1, w2, w3, w4, w5);
        step(1'b1, w0, 1'b0); step(1'b1, w1, 1'b0); step(1'b1, w2, 1'b0);
        step(1'b1, w3, 1'b0); step(1'b1, w4, 1'b0); step(1'b1, w5, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous effect before any edge.
    task automatic do_reset();
        s_valid = 1'b0; clear = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async", 1'b0);
        @(posedge clk);
        #1;
        cycle++;
        check_outputs("rst_held", 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_release.s_ready", 72'(s_ready), 72'(0));
    endtask

    initial begin
        int rv_before, issue_before;
        logic [31:0] w;

        // Reset state and s_ready rising one edge after release.
        model_reset();
        #1;
        check_outputs("init", 1'b0);
        @(posedge clk);
        #1;
        cycle++;
        rst_n = 1'b1;
        #1;
        check("release.s_ready", 72'(s_ready), 72'(0));
        idle(2);
        do_reset();
        idle(1);

        // Single pair: A = 2^72-1 region, B = 1; sum wraps to zero.
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'd1, 32'd0, 32'd0);
        check("t2.issue",  72'(issue), 72'(1));
        check("t2.din_a",  din_a, 72'hFF_FFFFFFFF_FFFFFFFF);
        check("t2.din_b",  din_b, 72'd1);
        idle(2);
        check("t2.pre_rv", 72'(res_valid), 72'(0));
        idle(1);
        check("t2.rv",     72'(res_valid), 72'(1));
        check("t2.dout",   din_a + din_b, 72'd0);
        idle(2);

        // Top-word truncation.
        send_pair($urandom, $urandom, 32'hDEAD_BEAD, $urandom, $urandom, $urandom);
        check("t3.din_a_top", 72'(din_a[71:64]), 72'(8'hAD));
        idle(5);

        // 100 back-to-back pairs with s_valid held high.
        rv_before = rv_seen;
        issue_before = issue_seen;
        for (int p = 0; p < 100; p++)
            send_pair($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        idle(LATENCY + 1);
        check("t4.issues",    72'(issue_seen - issue_before), 72'(100));
        check("t4.res_valid", 72'(rv_seen - rv_before),       72'(100));
        check("t4.pair_cnt",  72'(pair_cnt),                  72'(102));

        // clear after A plus one B word, then a clean pair.
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        step(1'b0, '0, 1'b1);
        check("t5.cnt_after_clear", 72'(pair_cnt), 72'(102));
        send_pair($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        check("t5.clean_issue", 72'(issue), 72'(1));
        idle(4);
        // clear coincident with the last B word suppresses the issue.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, $urandom, 1'b1);
        check("t5.clear_wins", 72'(issue), 72'(0));
        idle(1);
        check("t5.no_late_issue", 72'(issue), 72'(0));
        send_pair($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        idle(4);

        // Random 50% s_valid gaps with occasional clears.
        rv_before = rv_seen;
        for (int i = 0; i < 4000; i++) begin
            w = $urandom;
            step($urandom_range(0, 1) == 1, w, $urandom_range(0, 63) == 0);
        end
        idle(LATENCY + 1);
        check("t6.pair_cnt", 72'(pair_cnt), 72'(m_cnt));

        // Reset while a result is in flight: no res_valid may follow.
        send_pair($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        idle(1);
        rv_before = rv_seen;
        do_reset();
        idle(LATENCY + 3);
        check("t7.no_rv_after_reset", 72'(rv_seen - rv_before), 72'(0));
        check("t7.pair_cnt",          72'(pair_cnt),            72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
